// File: rtl/key_scan_ctrl.sv
// key_scan_ctrl: N-key debouncer sharing one timer round-robin, with event FIFO.
// Define KEY_RELEASE_EVT_EN to queue release events as well as presses.
module key_scan_ctrl #(
  parameter  int N_KEYS       = 4,
  parameter  int DEBOUNCE_CYC = 2_000_000,
  parameter  int FIFO_DEPTH   = 4,
  localparam int KW = $clog2(N_KEYS),
  localparam int CW = $clog2(DEBOUNCE_CYC),
  localparam int AW = $clog2(FIFO_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_level,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [KW-1:0]     evt_key,
  output logic              evt_press,
  output logic              evt_ovf,
  input  logic              ovf_clr
);

  localparam int KW1 = KW + 1;
  localparam int AW1 = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_TIME, S_COMMIT} state_t;

  state_t            st_q, st_d;
  logic [N_KEYS-1:0] s1_q, ks_q, lvl_q, lvl_d, mis, rot;
  logic [KW-1:0]     sel_q, sel_d, ptr_q, ptr_d, sel_inc, grant;
  logic [KW1-1:0]    off, sum;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              grant_vld, commit, new_lvl, push_req;
  logic              push_ok, pop, full, ovf_set, ovf_q;
  logic [KW-1:0]     kmem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_q, rd_q;
  logic [AW1-1:0]    occ_q, occ_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      ks_q <= '0;
    end else begin
      s1_q <= key_in;
      ks_q <= s1_q;
    end
  end

  assign mis       = ks_q ^ lvl_q;
  assign grant_vld = |mis;

  // rotate so bit 0 is ptr, lowest set bit is the grant offset
  always_comb begin
    rot = N_KEYS'({mis, mis} >> ptr_q);
    off = '0;
    for (int i = N_KEYS - 1; i >= 0; i--)
      if (rot[i]) off = KW1'(i);
    sum = {1'b0, ptr_q} + off;
    if (sum >= KW1'(N_KEYS)) sum = sum - KW1'(N_KEYS);
    grant = sum[KW-1:0];
  end

  assign sel_inc = (sel_q == KW'(N_KEYS - 1)) ? '0 : sel_q + KW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q  <= S_IDLE;
      sel_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
      lvl_q <= '0;
    end else begin
      st_q  <= st_d;
      sel_q <= sel_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      lvl_q <= lvl_d;
    end
  end

  always_comb begin
    st_d  = st_q;
    sel_d = sel_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    lvl_d = lvl_q;
    unique case (st_q)
      S_IDLE: begin
        if (grant_vld) begin
          sel_d = grant;
          cnt_d = '0;
          st_d  = S_TIME;
        end
      end
      S_TIME: begin
        if (!mis[sel_q]) begin
          ptr_d = sel_inc;
          st_d  = S_IDLE;
        end else if (cnt_q == CW'(DEBOUNCE_CYC - 1)) begin
          st_d = S_COMMIT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_COMMIT: begin
        lvl_d[sel_q] = ~lvl_q[sel_q];
        ptr_d        = sel_inc;
        st_d         = S_IDLE;
      end
      default: st_d = S_IDLE;
    endcase
  end

  assign commit  = (st_q == S_COMMIT);
  assign new_lvl = ~lvl_q[sel_q];

`ifdef KEY_RELEASE_EVT_EN
  assign push_req = commit;
`else
  assign push_req = commit & new_lvl;
`endif

  assign full    = (occ_q == AW1'(FIFO_DEPTH));
  assign pop     = evt_valid & evt_ready;
  assign push_ok = push_req & (~full | pop);
  assign ovf_set = push_req & full & ~pop;

  always_comb begin
    occ_d = occ_q;
    if (push_ok & ~pop)
      occ_d = occ_q + AW1'(1);
    else if (pop & ~push_ok)
      occ_d = occ_q - AW1'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      occ_q <= '0;
      ovf_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) kmem_q[i] <= '0;
    end else begin
      occ_q <= occ_d;
      if (push_ok) begin
        kmem_q[wr_q] <= sel_q;
        wr_q         <= wr_q + AW'(1);
      end
      if (pop) rd_q <= rd_q + AW'(1);
      if (ovf_set) ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
    end
  end

`ifdef KEY_RELEASE_EVT_EN
  logic pmem_q [FIFO_DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) pmem_q[i] <= 1'b0;
    end else if (push_ok) begin
      pmem_q[wr_q] <= new_lvl;
    end
  end

  assign evt_press = pmem_q[rd_q];
`else
  assign evt_press = 1'b1;
`endif

  assign key_level = lvl_q;
  assign evt_valid = (occ_q != '0);
  assign evt_key   = kmem_q[rd_q];
  assign evt_ovf   = ovf_q;

endmodule

// File: tb/tb_key_scan_ctrl.sv
// tb_key_scan_ctrl: directed table + corner sequences for key_scan_ctrl.
// Runs with N_KEYS=4, DEBOUNCE_CYC=8, FIFO_DEPTH=4, either macro setting.
module tb_key_scan_ctrl;
  localparam int N  = 4;
  localparam int DC = 8;
  localparam int D  = 4;

`ifdef KEY_RELEASE_EVT_EN
  localparam int RST_PRESS = 0;
`else
  localparam int RST_PRESS = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] key_in = '0;
  logic [3:0] key_level;
  logic       evt_valid;
  logic       evt_ready = 1'b0;
  logic [1:0] evt_key;
  logic       evt_press;
  logic       evt_ovf;
  logic       ovf_clr = 1'b0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  key_scan_ctrl #(
    .N_KEYS(N),
    .DEBOUNCE_CYC(DC),
    .FIFO_DEPTH(D)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .key_in(key_in),
    .key_level(key_level),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_key(evt_key),
    .evt_press(evt_press),
    .evt_ovf(evt_ovf),
    .ovf_clr(ovf_clr)
  );

  typedef struct {
    logic [3:0] kin;
    logic       rdy;
    logic       clr;
    int         n;
    logic [3:0] lvl;
    logic       v;
    logic [1:0] k;
    logic       p;
    logic       o;
  } vec_t;

  vec_t tbl[$];

  task automatic add(int kin, int rdy, int clr, int n,
                     int lvl, int v, int k, int p, int o);
    vec_t r;
    r.kin = 4'(kin); r.rdy = 1'(rdy); r.clr = 1'(clr); r.n = n;
    r.lvl = 4'(lvl); r.v = 1'(v); r.k = 2'(k); r.p = 1'(p);
    r.o = 1'(o);
    tbl.push_back(r);
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(string nm, int lvl, int v, int k, int p, int o);
    chk({nm, ".level"}, 32'(key_level), lvl);
    chk({nm, ".valid"}, 32'(evt_valid), v);
    chk({nm, ".ovf"}, 32'(evt_ovf), o);
    if (v != 0) begin
      chk({nm, ".key"}, 32'(evt_key), k);
      chk({nm, ".press"}, 32'(evt_press), p);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    key_in = '0;
    evt_ready = 1'b0;
    ovf_clr = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pop_one(string nm);
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
    chk({nm, ".popped"}, 32'(evt_valid), 0);
  endtask

  initial begin
    // reset state
    do_reset();
    chk_out("reset", 0, 0, 0, 0, 0);
    chk("reset.key", 32'(evt_key), 0);
    chk("reset.press", 32'(evt_press), RST_PRESS);

    // clean press of key 2: level at E+11, not at E+10
    key_in = 4'b0100;
    repeat (11) @(negedge clk);
    chk_out("press_e10", 'b0000, 0, 0, 0, 0);
    @(negedge clk);
    chk_out("press_e11", 'b0100, 1, 2, 1, 0);
    pop_one("press");

    // key 1 bounces with a 3-cycle half period, then settles high
    for (int c = 0; c < 42; c++) begin
      key_in[1] = ((c / 3) % 2 == 0);
      @(negedge clk);
    end
    key_in[1] = 1'b1;
    repeat (11) @(negedge clk);
    chk_out("bounce_e10", 'b0100, 0, 0, 0, 0);
    @(negedge clk);
    chk_out("bounce_e11", 'b0110, 1, 1, 1, 0);
    pop_one("bounce");

    // round-robin, release ordering, overflow, pop+push while full
    do_reset();
    add('b1001, 0, 0, 11, 'b0000, 0, 0, 0, 0);
    add('b1001, 0, 0,  1, 'b0001, 1, 0, 1, 0);
    add('b1000, 0, 0,  9, 'b0001, 1, 0, 1, 0);
    add('b1000, 0, 0,  1, 'b1001, 1, 0, 1, 0);
    add('b1000, 0, 0,  9, 'b1001, 1, 0, 1, 0);
    add('b1000, 0, 0,  1, 'b1000, 1, 0, 1, 0);
    add('b1000, 1, 0,  1, 'b1000, 1, 3, 1, 0);
`ifdef KEY_RELEASE_EVT_EN
    add('b1000, 1, 0,  1, 'b1000, 1, 0, 0, 0);
    add('b1000, 1, 0,  1, 'b1000, 0, 0, 0, 0);
    add('b0111, 0, 0, 42, 'b0111, 1, 1, 1, 0);
    add('b0110, 0, 0, 12, 'b0110, 1, 1, 1, 1);
    add('b0110, 1, 1,  1, 'b0110, 1, 2, 1, 0);
    add('b0110, 1, 0,  1, 'b0110, 1, 3, 0, 0);
    add('b0110, 1, 0,  1, 'b0110, 1, 0, 1, 0);
    add('b0110, 1, 0,  1, 'b0110, 0, 0, 0, 0);
    add('b1001, 0, 0, 42, 'b1001, 1, 1, 0, 0);
    add('b0001, 0, 0, 11, 'b1001, 1, 1, 0, 0);
    add('b0001, 1, 0,  1, 'b0001, 1, 2, 0, 0);
    add('b0001, 1, 0,  1, 'b0001, 1, 3, 1, 0);
    add('b0001, 1, 0,  1, 'b0001, 1, 0, 1, 0);
    add('b0001, 1, 0,  1, 'b0001, 1, 3, 0, 0);
    add('b0001, 1, 0,  1, 'b0001, 0, 0, 0, 0);
`else
    add('b1000, 1, 0,  1, 'b1000, 0, 0, 1, 0);
    add('b0111, 0, 0, 42, 'b0111, 1, 1, 1, 0);
    add('b1111, 0, 0, 12, 'b1111, 1, 1, 1, 0);
    add('b0111, 0, 0, 12, 'b0111, 1, 1, 1, 0);
    add('b1111, 0, 0, 12, 'b1111, 1, 1, 1, 1);
    add('b1111, 1, 1,  1, 'b1111, 1, 2, 1, 0);
    add('b1111, 1, 0,  1, 'b1111, 1, 0, 1, 0);
    add('b1111, 1, 0,  1, 'b1111, 1, 3, 1, 0);
    add('b1111, 1, 0,  1, 'b1111, 0, 0, 1, 0);
    add('b0000, 0, 0, 42, 'b0000, 0, 0, 1, 0);
    add('b1111, 0, 0, 42, 'b1111, 1, 0, 1, 0);
    add('b1110, 0, 0, 12, 'b1110, 1, 0, 1, 0);
    add('b1111, 0, 0, 11, 'b1110, 1, 0, 1, 0);
    add('b1111, 1, 0,  1, 'b1111, 1, 1, 1, 0);
    add('b1111, 1, 0,  1, 'b1111, 1, 2, 1, 0);
    add('b1111, 1, 0,  1, 'b1111, 1, 3, 1, 0);
    add('b1111, 1, 0,  1, 'b1111, 1, 0, 1, 0);
    add('b1111, 1, 0,  1, 'b1111, 0, 0, 1, 0);
`endif
    foreach (tbl[i]) begin
      key_in    = tbl[i].kin;
      evt_ready = tbl[i].rdy;
      ovf_clr   = tbl[i].clr;
      repeat (tbl[i].n) @(negedge clk);
      chk_out($sformatf("row%0d", i), 32'(tbl[i].lvl), 32'(tbl[i].v),
              32'(tbl[i].k), 32'(tbl[i].p), 32'(tbl[i].o));
    end
    evt_ready = 1'b0;
    ovf_clr   = 1'b0;

    // reset while key 1 is being timed (counter = 5)
    do_reset();
    key_in = 4'b1000;
    repeat (12) @(negedge clk);
    chk_out("pre_rst", 'b1000, 1, 3, 1, 0);
    key_in = 4'b1010;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_out("mid_rst", 0, 0, 0, 0, 0);
    chk("mid_rst.key", 32'(evt_key), 0);
    chk("mid_rst.press", 32'(evt_press), RST_PRESS);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (11) @(negedge clk);
    chk_out("post_rst_e10", 0, 0, 0, 0, 0);
    @(negedge clk);
    chk_out("post_rst_e11", 'b0010, 1, 1, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
